// File: rtl/seq_detector_param_if.sv
// rtl/seq_detector_param_if.sv - serial input and match status bundle for seq_detector_param
interface seq_detector_param_if #(
  parameter int CNT_W = 8
);
  logic             din;
  logic             din_valid;
  logic             overlap_en;
  logic             clear;
  logic             dout;
  logic [CNT_W-1:0] match_count;
  logic             count_ovf;

  modport master (
    output din, din_valid, overlap_en, clear,
    input  dout, match_count, count_ovf
  );

  modport slave (
    input  din, din_valid, overlap_en, clear,
    output dout, match_count, count_ovf
  );
endinterface

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector with match counter
// MSB of PATTERN is the first bit received; hist holds the newest bit in its LSB.
module seq_detector_param #(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b0110,
  parameter int             CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  seq_detector_param_if.slave bus
);
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  hist_n;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_n;
  logic              match;
  logic              dout_r;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;

  // fill gating keeps all-zero/all-one patterns from matching on reset history
  always_comb begin
    hist_n = {hist[PAT_W-2:0], bus.din};
    fill_n = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
    match  = bus.din_valid && (fill_n == FILL_FULL) && (hist_n == PATTERN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist   <= '0;
      fill   <= '0;
      dout_r <= 1'b0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (bus.clear) begin
      hist   <= '0;
      fill   <= '0;
      dout_r <= 1'b0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (bus.din_valid) begin
      hist   <= hist_n;
      dout_r <= match;
      if (match) begin
        cnt <= cnt + CNT_W'(1);
        if (&cnt)
          ovf <= 1'b1;
        // non-overlapping mode restarts the fill so the next match needs fresh bits
        fill <= bus.overlap_en ? fill_n : '0;
      end else begin
        fill <= fill_n;
      end
    end else begin
      dout_r <= 1'b0;
    end
  end

  assign bus.dout        = dout_r;
  assign bus.match_count = cnt;
  assign bus.count_ovf   = ovf;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param
module tb_seq_detector_param;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seq_detector_param_if #(.CNT_W(4)) bus ();
  seq_detector_param_if #(.CNT_W(4)) bus2 ();

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b0110), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  seq_detector_param #(.PAT_W(4), .PATTERN(4'b0000), .CNT_W(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2)
  );

  int tests = 0;
  int fails = 0;
  logic [4:0] q[$];
  logic [4:0] q2[$];
  logic [3:0] exp_cnt = 4'd0;
  logic       exp_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard monitors: every dout pulse must match the oldest expected {ovf,count}
  always @(negedge clk) begin
    if (reset_n && bus.dout === 1'b1) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got count %0d with no pulse expected", bus.match_count);
      end else begin
        logic [4:0] e;
        e = q.pop_front();
        if ({bus.count_ovf, bus.match_count} !== e) begin
          fails++;
          $display("FAIL pulse_status: got ovf=%0b cnt=%0d expected ovf=%0b cnt=%0d",
                   bus.count_ovf, bus.match_count, e[4], e[3:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && bus2.dout === 1'b1) begin
      tests++;
      if (q2.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse_p0000: got count %0d with no pulse expected", bus2.match_count);
      end else begin
        logic [4:0] e;
        e = q2.pop_front();
        if ({bus2.count_ovf, bus2.match_count} !== e) begin
          fails++;
          $display("FAIL pulse_status_p0000: got ovf=%0b cnt=%0d expected ovf=%0b cnt=%0d",
                   bus2.count_ovf, bus2.match_count, e[4], e[3:0]);
        end
      end
    end
  end

  task automatic drive(input logic b, input logic v, input logic clr, input logic pulse);
    bus.din = b;
    bus.din_valid = v;
    bus.clear = clr;
    if (clr) begin
      exp_cnt = 4'd0;
      exp_ovf = 1'b0;
    end else if (pulse) begin
      exp_cnt = exp_cnt + 4'd1;
      if (exp_cnt == 4'd0) exp_ovf = 1'b1;
      q.push_back({exp_ovf, exp_cnt});
    end
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic drive2(input logic b, input logic pulse);
    bus2.din = b;
    bus2.din_valid = 1'b1;
    if (pulse) q2.push_back(5'b0_0001);
    @(posedge clk);
    #1;
    bus2.din_valid = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w, input logic last_pulse);
    for (int i = 3; i >= 0; i--) drive(w[i], 1'b1, 1'b0, (i == 0) ? last_pulse : 1'b0);
  endtask

  task automatic drain(input string name);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check({name, "_drained"}, q.size(), 0);
  endtask

  task automatic check_status(input string name, input logic [3:0] c, input logic o);
    check({name, "_count"}, bus.match_count, c);
    check({name, "_ovf"}, bus.count_ovf, o);
  endtask

  initial begin
    bus.din = 0; bus.din_valid = 0; bus.overlap_en = 1; bus.clear = 0;
    bus2.din = 0; bus2.din_valid = 0; bus2.overlap_en = 0; bus2.clear = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", bus.dout, 0);
    check_status("reset", 4'd0, 1'b0);
    reset_n = 1'b1;

    // PATTERN=0000: only the 4th valid zero from reset may match
    drive2(1'b0, 1'b0);
    drive2(1'b0, 1'b0);
    drive2(1'b0, 1'b0);
    @(negedge clk);
    check("p0000_early_count", bus2.match_count, 0);
    drive2(1'b0, 1'b1);
    @(negedge clk);
    #1;
    check("p0000_count", bus2.match_count, 1);
    check("p0000_drained", q2.size(), 0);

    // basic match
    send_word(4'b0110, 1'b1);
    drain("basic");
    check_status("basic", 4'd1, 1'b0);

    // overlap on: 0110110 matches twice
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    bus.overlap_en = 1'b1;
    send_word(4'b0110, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drain("overlap");
    check_status("overlap", 4'd2, 1'b0);

    // overlap off: same stream matches once
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    bus.overlap_en = 1'b0;
    send_word(4'b0110, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drain("nonoverlap");
    check_status("nonoverlap", 4'd1, 1'b0);

    // gaps with din=1 do not disturb partial history
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check("gap_dout", bus.dout, 0);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drain("gap");
    check_status("gap", 4'd1, 1'b0);

    // counter wrap after 16 matches, then a 17th
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) send_word(4'b0110, 1'b1);
    drain("wrap");
    check_status("wrap", 4'd0, 1'b1);
    send_word(4'b0110, 1'b1);
    drain("wrap17");
    check_status("wrap17", 4'd1, 1'b1);

    // clear beats din_valid and discards the bit that would complete 0110
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    check("clear_dout", bus.dout, 0);
    check_status("clear", 4'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    send_word(4'b0110, 1'b1);
    drain("after_clear");
    check_status("after_clear", 4'd1, 1'b0);

    // asynchronous reset between edges mid-pattern
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_dout", bus.dout, 0);
    check_status("async_rst", 4'd0, 1'b0);
    check("async_rst_p0000_count", bus2.match_count, 0);
    exp_cnt = 4'd0;
    exp_ovf = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drain("lone_zero");
    check_status("lone_zero", 4'd0, 1'b0);
    send_word(4'b0110, 1'b1);
    drain("post_reset");
    check_status("post_reset", 4'd1, 1'b0);

    check("final_q2_empty", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
